tracklet_wr_arbiter: RTL and testbench

Round-robin write arbiter that merges tracklets from `N_REQ` tracklet engines into the single tracklet FIFO write port. It keeps the per-crossing tracklet count, saturates it instead of wrapping, and publishes the final count at each crossing boundary. It sits between the tracklet-engine outputs and the tracklet FIFO, and sequences FIFO writes against `fifo_full` and the `start` crossing marker.

---
 rtl/tracklet_wr_arbiter_pkg.sv | 17 +
 rtl/tracklet_wr_arbiter_if.sv | 29 ++
 rtl/tracklet_wr_arbiter_rr_pick.sv | 39 +++
 rtl/tracklet_wr_arbiter.sv | 124 ++++++++++++
 tb/tb_tracklet_wr_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tracklet_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tracklet_wr_arbiter_pkg
// Description : Shared constants and FSM encodings for the tracklet write path
// Revision    : 1.0 - initial release
// ============================================================================
package tracklet_wr_arbiter_pkg;

  localparam int TRACKLET_CNT_BITS = 16;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_RUN  = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/tracklet_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : tracklet_wr_arbiter_if
// Description : Requester bundle plus tracklet FIFO write port
// Revision    : 1.0 - initial release
// ============================================================================
interface tracklet_wr_arbiter_if #(
  parameter int N_REQ     = 4,
  parameter int WORD_BITS = 64
);
  logic [N_REQ-1:0]           req_x_valid;
  logic [N_REQ-1:0]           req_z_valid;
  logic [N_REQ*WORD_BITS-1:0] req_data;
  logic [N_REQ-1:0]           req_ack;
  logic                       fifo_full;
  logic                       fifo_wr;
  logic [WORD_BITS-1:0]       fifo_data;

  modport master (
    output req_x_valid, req_z_valid, req_data, fifo_full,
    input  req_ack, fifo_wr, fifo_data
  );

  modport slave (
    input  req_x_valid, req_z_valid, req_data, fifo_full,
    output req_ack, fifo_wr, fifo_data
  );
endinterface
`default_nettype wire

// File: rtl/tracklet_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker, priority starts at ptr
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N_REQ    = 4,
  parameter int PTR_BITS = $clog2(N_REQ)
) (
  input  wire logic [N_REQ-1:0]    req,
  input  wire logic [PTR_BITS-1:0] ptr,
  output logic      [N_REQ-1:0]    grant,
  output logic                     any
);

  logic [PTR_BITS:0]   w_sum;
  logic [PTR_BITS-1:0] w_idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    w_sum = '0;
    w_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // ptr + k folded back into 0..N_REQ-1 without a divider
      w_sum = {1'b0, ptr} + (PTR_BITS+1)'(k);
      if (w_sum >= (PTR_BITS+1)'(N_REQ))
        w_sum = w_sum - (PTR_BITS+1)'(N_REQ);
      w_idx = w_sum[PTR_BITS-1:0];
      if (!any && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        any          = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tracklet_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tracklet_wr_arbiter
// Description : Round-robin merge of tracklet engines into the tracklet FIFO
// Revision    : 1.0 - initial release
// ============================================================================
module tracklet_wr_arbiter
  import tracklet_wr_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WORD_BITS = 64,
  parameter int CNT_BITS  = TRACKLET_CNT_BITS
) (
  input  wire logic                clk,
  input  wire logic                clr,
  input  wire logic                start,
  tracklet_wr_arbiter_if.slave     bus,
  output logic      [CNT_BITS-1:0] cnt,
  output logic      [CNT_BITS-1:0] cnt_final,
  output logic                     cnt_final_valid,
  output logic                     overflow
);

  localparam int                  c_ptr_bits = $clog2(N_REQ);
  localparam logic [CNT_BITS-1:0] c_cnt_max  = '1;

  arb_state_t              r_state;
  logic [c_ptr_bits-1:0]   r_ptr;
  logic [CNT_BITS-1:0]     r_cnt;
  logic [CNT_BITS-1:0]     r_cnt_final;
  logic                    r_cnt_final_valid;
  logic                    r_overflow;
  logic                    r_fifo_wr;
  logic [WORD_BITS-1:0]    r_fifo_data;

  logic [N_REQ-1:0]        w_active;
  logic [N_REQ-1:0]        w_grant;
  logic                    w_any;
  logic                    w_sat;
  logic [N_REQ-1:0]        w_ack;
  logic [c_ptr_bits-1:0]   w_win_idx;
  logic [c_ptr_bits-1:0]   w_ptr_nxt;
  logic [WORD_BITS-1:0]    w_win_data;

  assign w_active = bus.req_x_valid & bus.req_z_valid;
  assign w_sat    = (r_cnt == c_cnt_max);

  rr_pick #(
    .N_REQ    (N_REQ),
    .PTR_BITS (c_ptr_bits)
  ) u_rr_pick (
    .req   (w_active),
    .ptr   (r_ptr),
    .grant (w_grant),
    .any   (w_any)
  );

  // At saturation the winner is still drained (and dropped) even when full
  always_comb begin
    w_ack = '0;
    if (!clr && r_state == ARB_RUN && !start && w_any && (w_sat || !bus.fifo_full))
      w_ack = w_grant;
  end

  always_comb begin
    w_win_idx  = '0;
    w_win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_win_idx  = c_ptr_bits'(i);
        w_win_data = bus.req_data[i*WORD_BITS +: WORD_BITS];
      end
    end
    w_ptr_nxt = (w_win_idx == c_ptr_bits'(N_REQ-1)) ? '0 : w_win_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state           <= ARB_IDLE;
      r_ptr             <= '0;
      r_cnt             <= '0;
      r_cnt_final       <= '0;
      r_cnt_final_valid <= 1'b0;
      r_overflow        <= 1'b0;
      r_fifo_wr         <= 1'b0;
      r_fifo_data       <= '0;
    end else begin
      r_fifo_wr         <= 1'b0;
      r_cnt_final_valid <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (start) r_state <= ARB_RUN;
        end
        ARB_RUN: begin
          if (start) begin
            r_cnt_final       <= r_cnt;
            r_cnt_final_valid <= 1'b1;
            r_cnt             <= '0;
            r_overflow        <= 1'b0;
          end else if (|w_ack) begin
            r_ptr <= w_ptr_nxt;
            if (w_sat) begin
              r_overflow <= 1'b1;
            end else begin
              r_fifo_wr   <= 1'b1;
              r_fifo_data <= w_win_data;
              r_cnt       <= r_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.req_ack     = w_ack;
  assign bus.fifo_wr     = r_fifo_wr;
  assign bus.fifo_data   = r_fifo_data;
  assign cnt             = r_cnt;
  assign cnt_final       = r_cnt_final;
  assign cnt_final_valid = r_cnt_final_valid;
  assign overflow        = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_tracklet_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tracklet_wr_arbiter
// Description : Directed scenarios plus randomized run against a crossing model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tracklet_wr_arbiter;

  localparam int N    = 4;
  localparam int W    = 64;
  localparam int CB   = 3;
  localparam int CMAX = 7;

  logic          clk = 1'b0;
  logic          clr, start, full;
  logic [N-1:0]  xv, zv;
  logic [W-1:0]  word [N];
  logic [CB-1:0] cnt, cnt_final;
  logic          cnt_final_valid, overflow;

  int n_checks = 0;
  int n_pass   = 0;

  tracklet_wr_arbiter_if #(.N_REQ(N), .WORD_BITS(W)) bus ();

  always_comb begin
    bus.req_x_valid = xv;
    bus.req_z_valid = zv;
    bus.fifo_full   = full;
    bus.req_data    = '0;
    for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = word[i];
  end

  tracklet_wr_arbiter #(.N_REQ(N), .WORD_BITS(W), .CNT_BITS(CB)) dut (
    .clk             (clk),
    .clr             (clr),
    .start           (start),
    .bus             (bus),
    .cnt             (cnt),
    .cnt_final       (cnt_final),
    .cnt_final_valid (cnt_final_valid),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [W-1:0] rnd_word();
    return {$urandom, $urandom};
  endfunction

  task automatic test_reset();
    clr = 1'b1; start = 1'b0; full = 1'b0; xv = '0; zv = '0;
    tick(); tick();
    clr = 1'b0; xv = '1; zv = '1;
    repeat (20) begin
      settle();
      n_checks++;
      if (bus.req_ack !== 4'b0) $display("FAIL idle_ack: got %b want 0000", bus.req_ack);
      else n_pass++;
      tick();
      n_checks++;
      if (bus.fifo_wr !== 1'b0) $display("FAIL idle_wr: got %b want 0", bus.fifo_wr);
      else n_pass++;
    end
    n_checks++;
    if (cnt !== 3'd0 || cnt_final !== 3'd0 || cnt_final_valid !== 1'b0 ||
        overflow !== 1'b0 || bus.fifo_data !== 64'd0)
      $display("FAIL reset_outputs: got cnt=%0d final=%0d fv=%b ovf=%b data=%h want all 0",
               cnt, cnt_final, cnt_final_valid, overflow, bus.fifo_data);
    else n_pass++;
    xv = '0; zv = '0;
  endtask

  task automatic test_round_robin();
    int ord [5] = '{0, 2, 3, 0, 2};
    logic [W-1:0] sent;
    for (int i = 0; i < N; i++) word[i] = rnd_word();
    xv = 4'b1101; zv = 4'b1101;
    start = 1'b1;
    settle();
    n_checks++;
    if (bus.req_ack !== 4'b0) $display("FAIL rr_start_ack: got %b want 0000", bus.req_ack);
    else n_pass++;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      settle();
      n_checks++;
      if (bus.req_ack !== 4'(1 << ord[k]))
        $display("FAIL rr_ack[%0d]: got %b want %b", k, bus.req_ack, 4'(1 << ord[k]));
      else n_pass++;
      sent = word[ord[k]];
      tick();
      word[ord[k]] = rnd_word();
      n_checks++;
      if (bus.fifo_wr !== 1'b1 || bus.fifo_data !== sent || cnt !== 3'(k + 1))
        $display("FAIL rr_write[%0d]: got wr=%b data=%h cnt=%0d want wr=1 data=%h cnt=%0d",
                 k, bus.fifo_wr, bus.fifo_data, cnt, sent, k + 1);
      else n_pass++;
    end
    xv = '0; zv = '0;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] sent;
    xv = 4'b1101; zv = 4'b1101; full = 1'b1;
    repeat (3) begin
      settle();
      n_checks++;
      if (bus.req_ack !== 4'b0) $display("FAIL bp_ack: got %b want 0000", bus.req_ack);
      else n_pass++;
      tick();
      n_checks++;
      if (bus.fifo_wr !== 1'b0 || cnt !== 3'd5)
        $display("FAIL bp_hold: got wr=%b cnt=%0d want wr=0 cnt=5", bus.fifo_wr, cnt);
      else n_pass++;
    end
    full = 1'b0;
    settle();
    n_checks++;
    if (bus.req_ack !== 4'b1000) $display("FAIL bp_resume_ack: got %b want 1000", bus.req_ack);
    else n_pass++;
    sent = word[3];
    tick();
    word[3] = rnd_word();
    n_checks++;
    if (bus.fifo_wr !== 1'b1 || bus.fifo_data !== sent || cnt !== 3'd6)
      $display("FAIL bp_resume_write: got wr=%b data=%h cnt=%0d want wr=1 data=%h cnt=6",
               bus.fifo_wr, bus.fifo_data, cnt, sent);
    else n_pass++;
    xv = '0; zv = '0;
  endtask

  task automatic test_crossing();
    word[1] = rnd_word();
    xv = 4'b0010; zv = 4'b0010; start = 1'b1;
    settle();
    n_checks++;
    if (bus.req_ack !== 4'b0) $display("FAIL cross_start_ack: got %b want 0000", bus.req_ack);
    else n_pass++;
    tick();
    start = 1'b0;
    n_checks++;
    if (cnt_final_valid !== 1'b1 || cnt_final !== 3'd6 || cnt !== 3'd0 || overflow !== 1'b0)
      $display("FAIL cross_close: got fv=%b final=%0d cnt=%0d ovf=%b want fv=1 final=6 cnt=0 ovf=0",
               cnt_final_valid, cnt_final, cnt, overflow);
    else n_pass++;
    settle();
    n_checks++;
    if (bus.req_ack !== 4'b0010) $display("FAIL cross_next_ack: got %b want 0010", bus.req_ack);
    else n_pass++;
    tick();
    xv = '0; zv = '0;
    n_checks++;
    if (bus.fifo_wr !== 1'b1 || cnt !== 3'd1 || cnt_final_valid !== 1'b0)
      $display("FAIL cross_new_count: got wr=%b cnt=%0d fv=%b want wr=1 cnt=1 fv=0",
               bus.fifo_wr, cnt, cnt_final_valid);
    else n_pass++;
    start = 1'b1;
    tick();
    n_checks++;
    if (cnt_final_valid !== 1'b1 || cnt_final !== 3'd1)
      $display("FAIL b2b_first: got fv=%b final=%0d want fv=1 final=1", cnt_final_valid, cnt_final);
    else n_pass++;
    tick();
    start = 1'b0;
    n_checks++;
    if (cnt_final_valid !== 1'b1 || cnt_final !== 3'd0)
      $display("FAIL b2b_second: got fv=%b final=%0d want fv=1 final=0", cnt_final_valid, cnt_final);
    else n_pass++;
  endtask

  task automatic test_saturation();
    int pend [N] = '{3, 2, 2, 2};
    int writes = 0;
    int drops  = 0;
    int left   = 9;
    int budget = 40;
    logic [N-1:0] a;
    while (left > 0 && budget > 0) begin
      budget--;
      for (int i = 0; i < N; i++) begin
        xv[i] = (pend[i] > 0);
        zv[i] = (pend[i] > 0);
      end
      full = (writes >= CMAX);
      settle();
      a = bus.req_ack;
      n_checks++;
      if (a == 4'b0 || (a & (a - 4'd1)) != 4'b0)
        $display("FAIL sat_ack_onehot: got %b want one-hot", a);
      else n_pass++;
      tick();
      for (int i = 0; i < N; i++) begin
        if (a[i]) begin
          pend[i]--;
          left--;
          if (bus.fifo_wr) writes++;
          else drops++;
        end
      end
    end
    xv = '0; zv = '0; full = 1'b0;
    n_checks++;
    if (left != 0 || writes != 7 || drops != 2 || cnt !== 3'd7 || overflow !== 1'b1)
      $display("FAIL sat_result: got left=%0d writes=%0d drops=%0d cnt=%0d ovf=%b want 0/7/2/7/1",
               left, writes, drops, cnt, overflow);
    else n_pass++;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (cnt_final_valid !== 1'b1 || cnt_final !== 3'd7 || overflow !== 1'b0 || cnt !== 3'd0)
      $display("FAIL sat_close: got fv=%b final=%0d ovf=%b cnt=%0d want fv=1 final=7 ovf=0 cnt=0",
               cnt_final_valid, cnt_final, overflow, cnt);
    else n_pass++;
  endtask

  task automatic test_clr_midstream();
    for (int i = 0; i < N; i++) word[i] = rnd_word();
    xv = '1; zv = '1;
    repeat (3) tick();
    n_checks++;
    if (bus.fifo_wr !== 1'b1 || cnt !== 3'd3)
      $display("FAIL clr_pre_stream: got wr=%b cnt=%0d want wr=1 cnt=3", bus.fifo_wr, cnt);
    else n_pass++;
    clr = 1'b1;
    settle();
    n_checks++;
    if (bus.req_ack !== 4'b0) $display("FAIL clr_ack: got %b want 0000", bus.req_ack);
    else n_pass++;
    tick();
    clr = 1'b0;
    n_checks++;
    if (bus.fifo_wr !== 1'b0 || cnt !== 3'd0 || cnt_final_valid !== 1'b0 || overflow !== 1'b0)
      $display("FAIL clr_state: got wr=%b cnt=%0d fv=%b ovf=%b want 0/0/0/0",
               bus.fifo_wr, cnt, cnt_final_valid, overflow);
    else n_pass++;
    settle();
    n_checks++;
    if (bus.req_ack !== 4'b0) $display("FAIL clr_idle_ack: got %b want 0000", bus.req_ack);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.fifo_wr !== 1'b0 || cnt_final_valid !== 1'b0)
      $display("FAIL clr_idle_out: got wr=%b fv=%b want 0/0", bus.fifo_wr, cnt_final_valid);
    else n_pass++;
    xv = '0; zv = '0;
  endtask

  // Crossing-level model: in a crossing, each cycle the first active
  // requester at or after ptr is taken unless start or a full FIFO intervenes.
  task automatic test_random();
    bit           m_run = 0;
    int           m_ptr = 0, m_cnt = 0, m_final = 0;
    bit           m_ovf = 0, m_fv = 0, m_wr = 0;
    logic [W-1:0] m_data = '0;
    logic [N-1:0] exp_ack;
    int           win;
    clr = 1'b1; start = 1'b0; full = 1'b0; xv = '0; zv = '0;
    tick();
    clr = 1'b0;
    for (int c = 0; c < 600; c++) begin
      start = ($urandom_range(0, 24) == 0);
      full  = ($urandom_range(0, 3) == 0);
      clr   = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N; i++) begin
        if (!xv[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            xv[i]   = 1'b1;
            zv[i]   = 1'($urandom_range(0, 1));
            word[i] = rnd_word();
          end
        end else if (!zv[i]) begin
          zv[i] = 1'($urandom_range(0, 1));
        end
      end
      settle();
      exp_ack = '0;
      win     = -1;
      if (!clr && m_run && !start && (m_cnt == CMAX || !full)) begin
        for (int k = 0; k < N; k++) begin
          if (win < 0 && xv[(m_ptr + k) % N] && zv[(m_ptr + k) % N])
            win = (m_ptr + k) % N;
        end
        if (win >= 0) exp_ack = 4'(1 << win);
      end
      n_checks++;
      if (bus.req_ack !== exp_ack)
        $display("FAIL rand_ack[%0d]: got %b want %b", c, bus.req_ack, exp_ack);
      else n_pass++;
      if (clr) begin
        m_run = 0; m_ptr = 0; m_cnt = 0; m_final = 0;
        m_ovf = 0; m_fv = 0; m_wr = 0; m_data = '0;
      end else begin
        m_wr = 0;
        m_fv = 0;
        if (!m_run) begin
          if (start) m_run = 1;
        end else if (start) begin
          m_final = m_cnt; m_fv = 1; m_cnt = 0; m_ovf = 0;
        end else if (win >= 0) begin
          m_ptr = (win + 1) % N;
          if (m_cnt == CMAX) m_ovf = 1;
          else begin
            m_wr = 1; m_data = word[win]; m_cnt = m_cnt + 1;
          end
        end
      end
      tick();
      if (win >= 0) begin
        xv[win] = 1'b0;
        zv[win] = 1'b0;
      end
      n_checks++;
      if (bus.fifo_wr !== m_wr || bus.fifo_data !== m_data || cnt !== 3'(m_cnt) ||
          cnt_final !== 3'(m_final) || cnt_final_valid !== m_fv || overflow !== m_ovf)
        $display("FAIL rand_out[%0d]: got wr=%b data=%h cnt=%0d final=%0d fv=%b ovf=%b want wr=%b data=%h cnt=%0d final=%0d fv=%b ovf=%b",
                 c, bus.fifo_wr, bus.fifo_data, cnt, cnt_final, cnt_final_valid, overflow,
                 m_wr, m_data, m_cnt, m_final, m_fv, m_ovf);
      else n_pass++;
    end
    clr = 1'b0; start = 1'b0; full = 1'b0; xv = '0; zv = '0;
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; full = 1'b0; xv = '0; zv = '0;
    for (int i = 0; i < N; i++) word[i] = '0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_crossing();
    test_saturation();
    test_clr_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
